// File: rtl/pipe_reg.sv
// pipe_reg: two-entry elastic pipeline stage built from a main register and a skid register.
// in_ready, out_valid and count all come straight from flops, so there is no
// combinational path from out_ready back to in_ready.
module pipe_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [1:0]       r_count;

    logic             w_in_xfer;
    logic             w_out_xfer;

    // Handshakes use the registered flags only.
    assign w_in_xfer  = in_valid & r_in_ready;
    assign w_out_xfer = r_out_valid & out_ready;

    // State, payload registers and status outputs, all updated together so they never disagree.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_EMPTY;
            r_main      <= RESET_VAL;
            r_skid      <= RESET_VAL;
            r_count     <= 2'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            // Drop all held entries; payload registers are left as they are.
            r_state     <= S_EMPTY;
            r_count     <= 2'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_xfer) begin
                        r_main      <= in_data;
                        r_state     <= S_ONE;
                        r_count     <= 2'd1;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        // Pass-through: new item replaces the one leaving.
                        r_main <= in_data;
                    end else if (w_in_xfer) begin
                        // Downstream stalled: park the new item in the skid register.
                        r_skid      <= in_data;
                        r_state     <= S_FULL;
                        r_count     <= 2'd2;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                    end else if (w_out_xfer) begin
                        r_state     <= S_EMPTY;
                        r_count     <= 2'd0;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                S_FULL: begin
                    // No input can arrive here because in_ready is low.
                    if (w_out_xfer) begin
                        r_main      <= r_skid;
                        r_state     <= S_ONE;
                        r_count     <= 2'd1;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_EMPTY;
                    r_count     <= 2'd0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;
    assign count     = r_count;

endmodule

// File: tb/tb_pipe_reg.sv
// Testbench for pipe_reg: directed vector table, a streaming sequence, and
// randomized traffic against a queue-based reference model.
module tb_pipe_reg;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [1:0]       count;

    int checks;
    int failures;

    pipe_reg #(.WIDTH(WIDTH), .RESET_VAL('0)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst_n;
        logic        flush;
        logic        in_valid;
        logic [31:0] in_data;
        logic        out_ready;
        logic        exp_valid;
        logic        exp_ready;
        logic [1:0]  exp_count;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[20];

    // Reference model: queue of held items plus the value last shown on out_data.
    logic [31:0] mq[$];
    logic [31:0] m_last;

    initial begin
        logic m_in, m_out, prev_hold;
        logic [31:0] prev_data;
        logic [31:0] dummy;
        logic r_rst, r_fl, r_iv, r_or;
        logic [31:0] r_id;
        int n_out;

        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        out_ready = 1'b0;

        //          rst fl iv data          ordy  v  r  cnt  data
        vecs[0]  = '{0, 0, 0, 32'h0,        0,    0, 1, 0, 32'h0};
        vecs[1]  = '{1, 0, 1, 32'hA5A5A5A5, 1,    1, 1, 1, 32'hA5A5A5A5};
        vecs[2]  = '{1, 0, 0, 32'h0,        1,    0, 1, 0, 32'hA5A5A5A5};
        vecs[3]  = '{1, 0, 1, 32'h11,       0,    1, 1, 1, 32'h11};
        vecs[4]  = '{1, 0, 1, 32'h22,       0,    1, 0, 2, 32'h11};
        vecs[5]  = '{1, 0, 1, 32'h99,       0,    1, 0, 2, 32'h11};
        vecs[6]  = '{1, 0, 0, 32'h0,        1,    1, 1, 1, 32'h22};
        vecs[7]  = '{1, 0, 0, 32'h0,        1,    0, 1, 0, 32'h22};
        vecs[8]  = '{1, 0, 1, 32'h33,       0,    1, 1, 1, 32'h33};
        vecs[9]  = '{1, 0, 1, 32'h44,       0,    1, 0, 2, 32'h33};
        vecs[10] = '{1, 1, 1, 32'h55,       0,    0, 1, 0, 32'h33};
        vecs[11] = '{1, 0, 1, 32'h66,       0,    1, 1, 1, 32'h66};
        vecs[12] = '{1, 1, 1, 32'h55,       1,    0, 1, 0, 32'h66};
        vecs[13] = '{1, 0, 0, 32'h0,        1,    0, 1, 0, 32'h66};
        vecs[14] = '{1, 0, 1, 32'h77,       0,    1, 1, 1, 32'h77};
        vecs[15] = '{1, 0, 1, 32'h88,       0,    1, 0, 2, 32'h77};
        vecs[16] = '{0, 1, 1, 32'h99,       1,    0, 1, 0, 32'h0};
        vecs[17] = '{1, 0, 1, 32'hBB,       0,    1, 1, 1, 32'hBB};
        vecs[18] = '{1, 0, 1, 32'hCC,       1,    1, 1, 1, 32'hCC};
        vecs[19] = '{1, 0, 0, 32'h0,        1,    0, 1, 0, 32'hCC};

        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 20; i++) begin
            rst_n     = vecs[i].rst_n;
            flush     = vecs[i].flush;
            in_valid  = vecs[i].in_valid;
            in_data   = vecs[i].in_data;
            out_ready = vecs[i].out_ready;
            @(posedge clk); #1;
            $display("vec %0d: v=%0b r=%0b cnt=%0d data=%h", i, out_valid, in_ready, count, out_data);
            check($sformatf("vec%0d.out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_valid});
            check($sformatf("vec%0d.in_ready", i),  {31'b0, in_ready},  {31'b0, vecs[i].exp_ready});
            check($sformatf("vec%0d.count", i),     {30'b0, count},     {30'b0, vecs[i].exp_count});
            check($sformatf("vec%0d.out_data", i),  out_data,           vecs[i].exp_data);
        end

        // Back-to-back stream 1..8 with downstream always ready: no bubbles.
        rst_n = 1'b1; flush = 1'b0; out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1;
            in_data  = k;
            check($sformatf("stream%0d.in_ready_pre", k), {31'b0, in_ready}, 32'd1);
            @(posedge clk); #1;
            $display("stream beat %0d: data=%h v=%0b", k, out_data, out_valid);
            check($sformatf("stream%0d.out_valid", k), {31'b0, out_valid}, 32'd1);
            check($sformatf("stream%0d.out_data", k),  out_data, k);
            check($sformatf("stream%0d.count", k),     {30'b0, count}, 32'd1);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("stream.drain_count", {30'b0, count}, 32'd0);

        // Randomized traffic against the queue model.
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mq.delete();
        m_last = 32'h0;
        n_out = 0;
        for (int c = 0; c < 10000; c++) begin
            r_rst = ($urandom_range(0, 511) != 0);
            r_fl  = ($urandom_range(0, 63) == 0);
            r_iv  = $urandom_range(0, 1) != 0;
            r_or  = $urandom_range(0, 3) != 0;
            r_id  = $urandom;
            rst_n = r_rst; flush = r_fl; in_valid = r_iv; in_data = r_id; out_ready = r_or;

            m_in      = r_iv && (mq.size() < 2);
            m_out     = (mq.size() > 0) && r_or;
            prev_hold = (mq.size() > 0) && !r_or;
            prev_data = out_data;

            @(posedge clk); #1;

            if (!r_rst) begin
                mq.delete();
                m_last = 32'h0;
            end else if (r_fl) begin
                mq.delete();
            end else begin
                if (m_out) begin
                    dummy = mq.pop_front();
                    n_out++;
                    $display("rand out #%0d: %h", n_out, dummy);
                end
                if (m_in) mq.push_back(r_id);
            end
            if (mq.size() > 0) m_last = mq[0];

            check("rand.count",     {30'b0, count},     mq.size());
            check("rand.out_valid", {31'b0, out_valid}, (mq.size() > 0) ? 32'd1 : 32'd0);
            check("rand.in_ready",  {31'b0, in_ready},  (mq.size() < 2) ? 32'd1 : 32'd0);
            check("rand.out_data",  out_data,           m_last);
            if (prev_hold && r_rst && !r_fl)
                check("rand.stall_stable", out_data, prev_data);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_reg.md
PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the payload width in bits.
REQ-002 Parameter RESET_VAL, default 0 (WIDTH bits), SHALL set the value out_data shows after reset.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL change only on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 flush  input  1  SHALL be the synchronous discard of all held entries, active high.
REQ-006 in_valid  input  1  SHALL indicate that in_data carries a valid upstream item.
REQ-007 in_data  input  WIDTH  SHALL be the upstream payload.
REQ-008 in_ready  output  1  SHALL indicate that the block accepts an item this cycle.
REQ-009 out_valid  output  1  SHALL indicate that out_data carries a valid item.
REQ-010 out_data  output  WIDTH  SHALL be the downstream payload.
REQ-011 out_ready  input  1  SHALL indicate that the downstream side accepts an item this cycle.
REQ-012 count  output  2  SHALL give the number of held entries (0, 1 or 2).

Function
REQ-013 The block SHALL hold a main register (drives out_data) and one skid register, and act as a 2-entry elastic pipeline stage.
REQ-014 Input transfer SHALL occur on an edge where in_valid=1 and in_ready=1; output transfer SHALL occur where out_valid=1 and out_ready=1.
REQ-015 State SHALL be one of EMPTY (count 0), ONE (count 1), or FULL (count 2).
REQ-016 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL, decoded from registered state only, with no combinational path from out_ready.
REQ-017 out_valid SHALL be 1 in ONE and FULL and 0 in EMPTY, decoded from registered state only.
REQ-018 In EMPTY with an input transfer, main SHALL load in_data and state SHALL go to ONE, giving 1-cycle latency.
REQ-019 In ONE with input and output transfer together, main SHALL load in_data and state SHALL stay ONE, sustaining 1 item/cycle.
REQ-020 In ONE with an input transfer and no output transfer, skid SHALL load in_data and state SHALL go to FULL.
REQ-021 In ONE with an output transfer and no input transfer, state SHALL go to EMPTY.
REQ-022 In FULL with an output transfer, main SHALL load skid and state SHALL go to ONE.
REQ-023 In FULL without an output transfer, main and skid SHALL hold.
REQ-024 Items SHALL leave in strict arrival order, with no item lost or duplicated.
REQ-025 When out_valid=1 and out_ready=0, out_data SHALL stay stable until the transfer.
REQ-026 flush=1 SHALL force state to EMPTY on that edge and discard any input transfer occurring in the same cycle.
REQ-027 Flush SHALL leave main and skid unchanged, so out_data holds its last value with out_valid=0.
REQ-028 In EMPTY, out_data SHALL hold the last main value; it is a don't-care for consumers.
REQ-029 count SHALL be registered and consistent with state on every cycle.

Reset
REQ-030 reset=0 at a rising edge SHALL force state EMPTY, count 0, out_valid 0, in_ready 1, and main = skid = RESET_VAL.
REQ-031 reset SHALL take priority over flush and all transfers, including mid-operation in FULL.
REQ-032 The first cycle after reset deasserts SHALL accept an input transfer.

Verification
REQ-033 Reset, then in_valid=1, in_data=0xA5A5A5A5, out_ready=1 for one cycle -> next cycle out_valid=1, out_data=0xA5A5A5A5, count=1.
REQ-034 Stream 0x1..0x8 on consecutive cycles with out_ready=1 -> outputs 0x1..0x8 on consecutive cycles with no bubble, in_ready constantly 1.
REQ-035 out_ready=0 while sending 0x11, 0x22 -> count=2, in_ready=0, out_data=0x11; then out_ready=1 -> 0x11 then 0x22 delivered, count falls 2->1->0.
REQ-036 In FULL holding 0x33 and 0x44, assert flush with in_valid=1 and in_data=0x55 -> next cycle count=0, out_valid=0, in_ready=1, and 0x55 never appears.
REQ-037 In FULL, drive reset=0 together with flush=1 -> next cycle count=0 and out_data=RESET_VAL (0 by default).
REQ-038 Random in_valid/out_ready stimulus over 10k cycles -> a scoreboard sees an in-order, lossless stream, and out_data never changes while out_valid=1 and out_ready=0.
